// File: rtl/sdram_arb.sv
// sdram_arb: two-client burst arbiter in front of one sdram_phy user port.
// Define SDRAM_ARB_FIXED_PRIO_EN for strict port-0 priority instead of round-robin.
module sdram_arb #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [LEN_W-1:0]  c0_len,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [LEN_W-1:0]  c1_len,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c0_gnt,
    output logic              c0_wr_ack,
    output logic              c0_rd_vld,
    output logic              c1_gnt,
    output logic              c1_wr_ack,
    output logic              c1_rd_vld,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sys_wraddr,
    output logic [ADDR_W-1:0] sys_rdaddr,
    output logic [LEN_W-1:0]  sdwr_byte,
    output logic [LEN_W-1:0]  sdrd_byte,
    output logic [DATA_W-1:0] sys_data_in,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    input  logic [DATA_W-1:0] sys_data_out,
    input  logic              sdram_busy,
    input  logic              sdram_init_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_DRAIN
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(256);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          gnt_q, gnt_d;

    logic                eligible;
    logic                pick1;
    logic                ack_match;
    logic                live;
    logic [LEN_W-1:0]    cnt_inc;
    logic [LEN_W-1:0]    raw_len;
    logic [LEN_W-1:0]    fit_len;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign pick1 = !c0_req;
`else
    logic                last_q, last_d;

    // last_q holds the port served last; the other port wins a tie
    assign pick1 = c1_req & (!c0_req | !last_q);
`endif

    assign eligible  = sdram_init_done & !sdram_busy & (c0_req | c1_req);
    assign ack_match = we_q ? sdram_wr_ack : sdram_rd_ack;
    assign cnt_inc   = cnt_q + ONE;
    assign raw_len   = pick1 ? c1_len : c0_len;

    always_comb begin
        fit_len = raw_len;
        if (raw_len == '0) begin
            fit_len = ONE;
        end else if (raw_len > MAX_LEN) begin
            fit_len = MAX_LEN;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (eligible) begin
                    owner_d = pick1;
                    we_d    = pick1 ? c1_we : c0_we;
                    addr_d  = pick1 ? c1_addr : c0_addr;
                    len_d   = fit_len;
                    cnt_d   = '0;
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ack_match) begin
                    cnt_d   = ONE;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end else if (ack_match) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!sdram_busy) begin
                    state_d = S_IDLE;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                    last_d  = owner_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

`ifndef SDRAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // strobes stop once the full burst has been counted
    assign live = (state_q == S_ISSUE) |
                  ((state_q == S_XFER) & (cnt_q != len_q));

    assign sdram_wr_req = (state_q == S_ISSUE) & we_q;
    assign sdram_rd_req = (state_q == S_ISSUE) & !we_q;
    assign sys_wraddr   = addr_q;
    assign sys_rdaddr   = addr_q;
    assign sdwr_byte    = len_q;
    assign sdrd_byte    = len_q;
    assign sys_data_in  = owner_q ? c1_wdata : c0_wdata;
    assign rdata        = sys_data_out;
    assign busy         = (state_q != S_IDLE);

    assign c0_gnt    = gnt_q[0];
    assign c1_gnt    = gnt_q[1];
    assign c0_wr_ack = live & sdram_wr_ack & !owner_q & we_q;
    assign c1_wr_ack = live & sdram_wr_ack & owner_q & we_q;
    assign c0_rd_vld = live & sdram_rd_ack & !owner_q & !we_q;
    assign c1_rd_vld = live & sdram_rd_ack & owner_q & !we_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Randomized scoreboard bench for sdram_arb with a behavioural phy memory.
// Grant order, burst data and strobe counts come from a queue-level model.
module tb_sdram_arb;

    localparam int AW = 21;
    localparam int DW = 32;
    localparam int LW = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          c0_req = 0, c1_req = 0, c0_we = 0, c1_we = 0;
    logic [AW-1:0] c0_addr = '0, c1_addr = '0;
    logic [LW-1:0] c0_len = '0, c1_len = '0;
    logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
    logic          c0_gnt, c0_wr_ack, c0_rd_vld;
    logic          c1_gnt, c1_wr_ack, c1_rd_vld;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          sdram_wr_req, sdram_rd_req;
    logic [AW-1:0] sys_wraddr, sys_rdaddr;
    logic [LW-1:0] sdwr_byte, sdrd_byte;
    logic [DW-1:0] sys_data_in;
    logic          sdram_wr_ack = 0, sdram_rd_ack = 0;
    logic [DW-1:0] sys_data_out = '0;
    logic          sdram_busy = 0, sdram_init_done = 0;

    sdram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr),
        .c0_len(c0_len), .c0_wdata(c0_wdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr),
        .c1_len(c1_len), .c1_wdata(c1_wdata),
        .c0_gnt(c0_gnt), .c0_wr_ack(c0_wr_ack), .c0_rd_vld(c0_rd_vld),
        .c1_gnt(c1_gnt), .c1_wr_ack(c1_wr_ack), .c1_rd_vld(c1_rd_vld),
        .rdata(rdata), .busy(busy),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sys_wraddr(sys_wraddr), .sys_rdaddr(sys_rdaddr),
        .sdwr_byte(sdwr_byte), .sdrd_byte(sdrd_byte),
        .sys_data_in(sys_data_in),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .sys_data_out(sys_data_out), .sdram_busy(sdram_busy),
        .sdram_init_done(sdram_init_done)
    );

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } burst_t;

    int n_chk = 0;
    int n_fail = 0;

    burst_t        gq[$];
    logic [DW-1:0] wq0[$], wq1[$], rq0[$], rq1[$];
    logic [DW-1:0] pmem[1024];
    logic [DW-1:0] refmem[1024];
    int            obs_w[2], obs_r[2], exp_w[2], exp_r[2];
    bit            last_srv = 1'b1;
    bit            cur_owner = 1'b0;
    bit            drop0 = 0, drop1 = 0, adv0 = 0, adv1 = 0;
    bit            prev_req = 0, prev_ack = 0;
    int            phase = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] cl(input logic [LW-1:0] l);
        if (l == 0) return LW'(1);
        if (l > LW'(256)) return LW'(256);
        return l;
    endfunction

    // behavioural phy: random start latency and random gaps between words
    initial begin
        bit       pw;
        logic [9:0] pa, ca;
        int       pl, pi, wt;
        pw = 0; pa = '0; ca = '0; pl = 0; pi = 0; wt = 0;
        forever begin
            @(posedge clk);
            #1;
            sdram_wr_ack = 0;
            sdram_rd_ack = 0;
            if (!rst_n) begin
                phase = 0;
                sdram_busy = 0;
            end else begin
                if (phase == 3) begin
                    sdram_busy = 0;
                    phase = 0;
                end else if (phase == 0 && (sdram_wr_req || sdram_rd_req)) begin
                    pw = sdram_wr_req;
                    pa = pw ? sys_wraddr[9:0] : sys_rdaddr[9:0];
                    pl = int'(pw ? sdwr_byte : sdrd_byte);
                    pi = 0;
                    wt = $urandom_range(0, 2);
                    sdram_busy = 1;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (wt == 0) phase = 2;
                    else wt--;
                end
                if (phase == 2 && !(pi != 0 && $urandom_range(0, 3) == 0)) begin
                    ca = 10'(int'(pa) + pi);
                    if (pw) begin
                        sdram_wr_ack = 1;
                    end else begin
                        sdram_rd_ack = 1;
                        sys_data_out = pmem[ca];
                    end
                    pi++;
                    if (pi >= pl) phase = 3;
                end
            end
            @(negedge clk);
            if (rst_n && sdram_wr_ack) pmem[ca] = sys_data_in;
        end
    end

    // client side: drop request after grant, advance write data after ack
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (drop0) begin c0_req = 0; drop0 = 0; end
            if (drop1) begin c1_req = 0; drop1 = 0; end
            if (adv0) begin adv0 = 0; if (wq0.size() > 0) wq0.delete(0); end
            if (adv1) begin adv1 = 0; if (wq1.size() > 0) wq1.delete(0); end
            c0_wdata = (wq0.size() > 0) ? wq0[0] : '0;
            c1_wdata = (wq1.size() > 0) ? wq1[0] : '0;
        end
    end

    // monitor: pops expected grants and read words as the DUT presents them
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 0;
            end else begin
                if (c0_gnt || c1_gnt) begin
                    burst_t b;
                    chk("gnt_onehot", 64'(c0_gnt & c1_gnt), 64'(0));
                    chk("gnt_expected", 64'(gq.size() > 0), 64'(1));
                    if (gq.size() > 0) begin
                        b = gq.pop_front();
                        chk("gnt_port", 64'(c1_gnt), 64'(b.port));
                        chk("phy_wraddr", 64'(sys_wraddr), 64'(b.addr));
                        chk("phy_rdaddr", 64'(sys_rdaddr), 64'(b.addr));
                        chk("phy_len", 64'(sdwr_byte), 64'(b.len));
                        chk("phy_wr_req", 64'(sdram_wr_req), 64'(b.we));
                        chk("phy_rd_req", 64'(sdram_rd_req), 64'(!b.we));
                    end
                    cur_owner = c1_gnt;
                    if (c1_gnt) drop1 = 1;
                    else drop0 = 1;
                end
                if (c0_wr_ack || c0_rd_vld) chk("owner0_strobe", 64'(cur_owner), 64'(0));
                if (c1_wr_ack || c1_rd_vld) chk("owner1_strobe", 64'(cur_owner), 64'(1));
                if (c0_wr_ack) begin obs_w[0]++; adv0 = 1; end
                if (c1_wr_ack) begin obs_w[1]++; adv1 = 1; end
                if (c0_rd_vld) begin
                    obs_r[0]++;
                    chk("rq0_nonempty", 64'(rq0.size() > 0), 64'(1));
                    if (rq0.size() > 0) chk("rdata0", 64'(rdata), 64'(rq0.pop_front()));
                end
                if (c1_rd_vld) begin
                    obs_r[1]++;
                    chk("rq1_nonempty", 64'(rq1.size() > 0), 64'(1));
                    if (rq1.size() > 0) chk("rdata1", 64'(rdata), 64'(rq1.pop_front()));
                end
                if (prev_req) chk("req_hold", 64'(sdram_wr_req | sdram_rd_req), 64'(!prev_ack));
                prev_req = sdram_wr_req | sdram_rd_req;
                prev_ack = (sdram_wr_req & sdram_wr_ack) | (sdram_rd_req & sdram_rd_ack);
            end
        end
    end

    // mode 0: normal, 1: init-gate check, 2: reset during word 100
    task automatic do_round(input bit r0, input bit r1, input bit we0, input bit we1,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                            input int mode);
        bit     order[$];
        bit     first;
        burst_t b;
        logic [9:0] idx;
        logic [DW-1:0] d;
        int     base;
        bit     done;
        if (r0 && r1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            first = 1'b0;
`else
            first = !last_srv;
`endif
            order.push_back(first);
            order.push_back(!first);
        end else begin
            order.push_back(r1);
        end
        foreach (order[i]) begin
            b.port = order[i];
            b.we   = b.port ? we1 : we0;
            b.addr = b.port ? a1 : a0;
            b.len  = cl(b.port ? l1 : l0);
            gq.push_back(b);
            for (int k = 0; k < int'(b.len); k++) begin
                idx = 10'(int'(b.addr[9:0]) + k);
                if (b.we) begin
                    d = $urandom;
                    refmem[idx] = d;
                    if (b.port) wq1.push_back(d);
                    else wq0.push_back(d);
                end else begin
                    if (b.port) rq1.push_back(refmem[idx]);
                    else rq0.push_back(refmem[idx]);
                end
            end
            if (mode != 2) begin
                if (b.we) exp_w[b.port] += int'(b.len);
                else exp_r[b.port] += int'(b.len);
            end
            last_srv = b.port;
        end
        if (mode == 1) sdram_init_done = 0;
        base = obs_w[0];
        @(posedge clk);
        #1;
        c0_we = we0; c1_we = we1;
        c0_addr = a0; c1_addr = a1;
        c0_len = l0; c1_len = l1;
        c0_req = r0; c1_req = r1;
        if (mode == 1) begin
            repeat (8) begin
                @(negedge clk);
                chk("init_gate_gnt", 64'(c0_gnt | c1_gnt), 64'(0));
                chk("init_gate_req", 64'(sdram_wr_req | sdram_rd_req), 64'(0));
            end
            @(posedge clk);
            #1;
            sdram_init_done = 1;
            @(negedge clk);
            chk("init_gnt_early", 64'(c0_gnt | c1_gnt), 64'(0));
            @(negedge clk);
            chk("init_gnt_latency", 64'(c0_gnt | c1_gnt), 64'(1));
        end
        if (mode == 2) begin
            done = 0;
            for (int t = 0; t < 3000 && !done; t++) begin
                @(negedge clk);
                #1;
                if (obs_w[0] == base + 100) done = 1;
            end
            chk("rst_reach_word100", 64'(done), 64'(1));
            rst_n = 0;
            #1;
            chk("rst_strobes", 64'({c0_gnt, c1_gnt, c0_wr_ack, c1_wr_ack, c0_rd_vld, c1_rd_vld}), 64'(0));
            chk("rst_phy_req", 64'({sdram_wr_req, sdram_rd_req}), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_addr", 64'(sys_wraddr), 64'(0));
            chk("rst_len", 64'(sdwr_byte), 64'(0));
            repeat (3) @(negedge clk);
            gq.delete();
            wq0.delete();
            drop0 = 0;
            adv0 = 0;
            c0_req = 0;
            cur_owner = 0;
            last_srv = 1'b1;
            exp_w[0] += 100;
            rst_n = 1;
            repeat (2) @(negedge clk);
            return;
        end
        done = 0;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(negedge clk);
            if (gq.size() == 0 && !busy && !sdram_busy && !c0_req && !c1_req) done = 1;
        end
        chk("round_done", 64'(done), 64'(1));
        for (int p = 0; p < 2; p++) begin
            chk("wr_ack_count", 64'(obs_w[p]), 64'(exp_w[p]));
            chk("rd_vld_count", 64'(obs_r[p]), 64'(exp_r[p]));
        end
        chk("rd_left", 64'(rq0.size() + rq1.size()), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] la, lb;
        for (int i = 0; i < 1024; i++) begin
            pmem[i] = DW'(i * 3 + 7);
            refmem[i] = DW'(i * 3 + 7);
        end
        for (int p = 0; p < 2; p++) begin
            obs_w[p] = 0; obs_r[p] = 0; exp_w[p] = 0; exp_r[p] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_strobes", 64'({c0_gnt, c1_gnt, c0_wr_ack, c1_wr_ack, c0_rd_vld, c1_rd_vld}), 64'(0));
        chk("reset_phy_req", 64'({sdram_wr_req, sdram_rd_req}), 64'(0));
        chk("reset_addr", 64'({sys_wraddr, sys_rdaddr}), 64'(0));
        chk("reset_len", 64'({sdwr_byte, sdrd_byte}), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        rst_n = 1;

        do_round(1, 0, 1, 0, 21'd0, 21'd0, 9'd256, 9'd0, 1);
        do_round(0, 1, 0, 0, 21'd0, 21'd0, 9'd0, 9'd2, 0);
        repeat (3) do_round(1, 1, 1, 0, 21'd300, 21'd0, 9'd5, 9'd7, 0);
        do_round(1, 0, 1, 0, 21'd40, 21'd0, 9'd0, 9'd0, 0);
        do_round(0, 1, 0, 1, 21'd0, 21'd500, 9'd0, 9'd300, 0);

        for (int r = 0; r < 40; r++) begin
            la = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 511)) : LW'($urandom_range(1, 40));
            lb = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 511)) : LW'($urandom_range(1, 40));
            do_round(1'($urandom_range(0, 1)) | (r % 3 == 0), 1'($urandom_range(0, 1)) | (r % 3 != 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 511)), AW'($urandom_range(0, 511)), la, lb, 0);
        end

        do_round(1, 0, 1, 0, 21'd768, 21'd0, 9'd256, 9'd0, 2);
        do_round(1, 0, 0, 0, 21'd0, 21'd0, 9'd4, 9'd0, 0);
        last_srv = 1'b1;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_round(1, 1, 0, 0, 21'd10, 21'd20, 9'd3, 9'd3, 0);

        for (int i = 0; i < 768; i++) chk("mem_word", 64'(pmem[i]), 64'(refmem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
